aes128_ctr_stream: RTL and testbench

Counter-mode (CTR) stream front-end for the AES-128 encrypt core, one level above it in the datapath. The block owns the key/IV, generates successive counter blocks, drives them into an externally instantiated fixed-latency AES-128 encrypt core, and buffers the returned keystream in a small FIFO. Incoming 128-bit data blocks are XORed with the keystream under valid/ready handshakes. Encryption and decryption are the same operation.

---
 rtl/aes128_ctr_stream.sv | 145 ++++++++++++++
 tb/tb_aes128_ctr_stream.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_ctr_stream.sv
// AES-128 CTR stream front-end: counter generation, keystream FIFO, XOR datapath.
// Define AES_CTR_WRAP_STOP_EN to halt generation when the counter field wraps.
module aes128_ctr_stream #(
  parameter int CORE_LATENCY = 20,
  parameter int CTR_WIDTH    = 32,
  parameter int DEPTH        = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  key_0,
  input  logic [31:0]  key_1,
  input  logic [31:0]  key_2,
  input  logic [31:0]  key_3,
  input  logic [31:0]  iv_0,
  input  logic [31:0]  iv_1,
  input  logic [31:0]  iv_2,
  input  logic [31:0]  iv_3,
  input  logic         load,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [127:0] core_key,
  output logic [127:0] core_plain_text,
  input  logic [127:0] core_cipher_text,
  output logic         busy,
  output logic [31:0]  blk_count,
  output logic         ctr_wrap
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, STOP} state_t;

  state_t         state_q, state_d;
  logic [7:0]     wait_q, wait_d;
  logic [127:0]   key_q;
  logic [127:0]   ctr_q, ctr_d;
  logic           wrap_q, wrap_d;
  logic [127:0]   fifo_q [DEPTH];
  logic [AW-1:0]  wr_q, rd_q;
  logic [AW:0]    cnt_q, cnt_d;
  logic           ov_q;
  logic [127:0]   od_q;
  logic [31:0]    blk_q;
  logic           push, pop, full, empty, ctr_last;

  assign full     = cnt_q == (AW+1)'(DEPTH);
  assign empty    = cnt_q == '0;
  assign busy     = state_q != IDLE;
  assign in_ready = busy && !empty && (!ov_q || out_ready) && !load;
  assign pop      = in_valid && in_ready;
  assign ctr_last = &ctr_q[CTR_WIDTH-1:0];
  assign cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign out_valid       = ov_q;
  assign out_data        = od_q;
  assign core_key        = key_q;
  assign core_plain_text = ctr_q;
  assign blk_count       = blk_q;
  assign ctr_wrap        = wrap_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctr_d   = ctr_q;
    wrap_d  = wrap_q;
    push    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (wait_q == 8'(CORE_LATENCY - 1)) begin
          if (!full || pop) push = 1'b1;
          else              state_d = HOLD;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      HOLD: begin
        if (!full || pop) push = 1'b1;
      end
      default: ;
    endcase
    if (push) begin
      wait_d  = '0;
      state_d = RUN;
      ctr_d[CTR_WIDTH-1:0] = ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
      if (ctr_last) begin
        wrap_d = 1'b1;
`ifdef AES_CTR_WRAP_STOP_EN
        state_d = STOP;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q  <= '0;
      key_q   <= '0;
      ctr_q   <= '0;
      wrap_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      blk_q   <= '0;
    end else if (load) begin
      state_q <= RUN;
      wait_q  <= '0;
      key_q   <= {key_3, key_2, key_1, key_0};
      ctr_q   <= {iv_3, iv_2, iv_1, iv_0};
      wrap_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctr_q   <= ctr_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) begin
        rd_q  <= rd_q + AW'(1);
        od_q  <= in_data ^ fifo_q[rd_q];
        ov_q  <= 1'b1;
        blk_q <= blk_q + 32'd1;
      end else if (out_ready) begin
        ov_q  <= 1'b0;
      end
    end
  end

  // Keystream storage carries no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (!reset && !load && push) fifo_q[wr_q] <= core_cipher_text;
  end

endmodule

// File: tb/tb_aes128_ctr_stream.sv
// Bench for aes128_ctr_stream with a key^counter core stub and a CTR scoreboard.
// Expectations follow AES_CTR_WRAP_STOP_EN when it is defined.
module tb_aes128_ctr_stream;
  localparam int LAT   = 20;
  localparam int CW    = 32;
  localparam int DEPTH = 4;
  localparam logic [127:0] K = 128'h100F0E0D0C0B0A090807060504030201;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  key_0 = '0, key_1 = '0, key_2 = '0, key_3 = '0;
  logic [31:0]  iv_0 = '0, iv_1 = '0, iv_2 = '0, iv_3 = '0;
  logic         load = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy, ctr_wrap;
  logic [127:0] out_data, core_key, core_plain_text, core_cipher_text;
  logic [31:0]  blk_count;

  always #5 clk = ~clk;

  aes128_ctr_stream #(.CORE_LATENCY(LAT), .CTR_WIDTH(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .key_0(key_0), .key_1(key_1), .key_2(key_2), .key_3(key_3),
    .iv_0(iv_0), .iv_1(iv_1), .iv_2(iv_2), .iv_3(iv_3),
    .load(load), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_key(core_key), .core_plain_text(core_plain_text),
    .core_cipher_text(core_cipher_text),
    .busy(busy), .blk_count(blk_count), .ctr_wrap(ctr_wrap)
  );

  // Core stub: result visible LAT cycles after the counter block changes.
  logic [127:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= core_plain_text ^ core_key;
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign core_cipher_text = pipe[LAT-2];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
    end
  endtask

  // Reference: block n of a stream uses counter IV + n in the low field.
  logic [127:0] key_m = '0, iv_m = '0;
  int unsigned  n_in = 0;
  logic [127:0] expq [$];

  function automatic logic [127:0] ks(input int unsigned n);
    logic [127:0] c;
    c = iv_m;
    c[CW-1:0] = iv_m[CW-1:0] + CW'(n);
    return c ^ key_m;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("blk_count", 128'(blk_count), 128'(n_in));
      chk("out_valid", 128'(out_valid), 128'(expq.size() != 0));
      if (out_valid && expq.size() != 0) chk("out_data", out_data, expq[0]);
    end
    if (reset) begin
      expq.delete();
      n_in = 0;
    end else if (load) begin
      expq.delete();
      n_in = 0;
      key_m = {key_3, key_2, key_1, key_0};
      iv_m  = {iv_3, iv_2, iv_1, iv_0};
    end else begin
      if (out_valid && out_ready && expq.size() != 0) void'(expq.pop_front());
      if (in_valid && in_ready) begin
        expq.push_back(in_data ^ ks(n_in));
        n_in++;
      end
    end
  end

  task automatic do_load(input logic [127:0] k, input logic [127:0] iv);
    {key_3, key_2, key_1, key_0} = k;
    {iv_3, iv_2, iv_1, iv_0} = iv;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic xfer(input logic [127:0] din, output logic [127:0] dout);
    int t;
    t = 0;
    in_data = din;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("xfer_ready", 128'(in_ready), 128'(1));
    if (in_ready) begin
      @(posedge clk); #1;
      dout = out_data;
    end else begin
      dout = 'x;
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  typedef struct {
    logic [127:0] key, iv, d0, d1, e0, e1;
  } vec_t;

  vec_t         vt [4];
  logic [127:0] r, k2, iv2, d;
  logic [127:0] pt [5];
  logic [127:0] ct [5];
  int           k, n;

  initial begin
    vt[0] = '{K, 128'h0, 128'h0, 128'h0, K,
              128'h100F0E0D0C0B0A090807060504030200};
    vt[1] = '{128'h0, 128'h11111111222222223333333344444444, 128'h0, 128'h0,
              128'h11111111222222223333333344444444,
              128'h11111111222222223333333344444445};
    vt[2] = '{{128{1'b1}}, 128'h0, {128{1'b1}}, 128'h0, 128'h0,
              128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE};
    vt[3] = '{K, K, 128'hDEADBEEF0123456789ABCDEFCAFEF00D, 128'h0,
              128'hDEADBEEF0123456789ABCDEFCAFEF00D, 128'h3};

    // Reset values
    repeat (50) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_core_pt", core_plain_text, 128'h0);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_blk_count", 128'(blk_count), 128'(0));
    chk("rst_ctr_wrap", 128'(ctr_wrap), 128'(0));
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_in_ready", 128'(in_ready), 128'(0));

    // First-push timing and the first two blocks
    in_data = '0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    do_load(K, 128'h0);
    chk("load_core_key", core_key, K);
    k = 0;
    while (!in_ready && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk("first_ready_cycle", 128'(k), 128'(LAT));
    @(posedge clk); #1;
    chk("blk0", out_data, K);
    k = 0;
    while (!in_ready && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    chk("blk1", out_data, 128'h100F0E0D0C0B0A090807060504030200);
    in_valid = 1'b0;
    chk("blk_count_2", 128'(blk_count), 128'(2));

    // Table vectors
    for (int i = 0; i < 4; i++) begin
      do_load(vt[i].key, vt[i].iv);
      xfer(vt[i].d0, r);
      chk($sformatf("vec%0d_b0", i), r, vt[i].e0);
      xfer(vt[i].d1, r);
      chk($sformatf("vec%0d_b1", i), r, vt[i].e1);
    end

    // Back-pressure: FIFO fills, held block stays stable, then drains
    out_ready = 1'b0;
    do_load(K, 128'h0);
    in_data = rnd128();
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("hold_ctr", core_plain_text, 128'h5);
    chk("hold_in_ready", 128'(in_ready), 128'(0));
    chk("hold_out_valid", 128'(out_valid), 128'(1));
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = rnd128();
    #1;
    n = 0;
    while (in_ready && n < 10) begin
      @(posedge clk); #1;
      in_data = rnd128();
      n++;
    end
    // The held keystream block enters as the first buffered one leaves.
    chk("burst_len", 128'(n), 128'(DEPTH + 1));
    in_valid = 1'b0;

    // Counter wrap
    do_load(128'h0, 128'h0123456789ABCDEF00112233FFFFFFFE);
    chk("wrap_clear", 128'(ctr_wrap), 128'(0));
    xfer(128'h0, r);
    chk("wrap_b0", r, 128'h0123456789ABCDEF00112233FFFFFFFE);
    chk("wrap_early", 128'(ctr_wrap), 128'(0));
    xfer(128'h0, r);
    chk("wrap_b1", r, 128'h0123456789ABCDEF00112233FFFFFFFF);
    chk("wrap_flag", 128'(ctr_wrap), 128'(1));
`ifdef AES_CTR_WRAP_STOP_EN
    in_valid = 1'b1;
    n = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (in_ready) n++;
    end
    in_valid = 1'b0;
    chk("stop_no_ready", 128'(n), 128'(0));
    chk("stop_busy", 128'(busy), 128'(1));
`else
    xfer(128'h0, r);
    chk("wrap_b2", r, 128'h0123456789ABCDEF0011223300000000);
`endif
    chk("wrap_sticky", 128'(ctr_wrap), 128'(1));

    // Reload with three keystream blocks buffered and an output pending
    out_ready = 1'b0;
    do_load(K, 128'h0);
    in_data = rnd128();
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (65) @(posedge clk);
    #1;
    k2  = rnd128();
    iv2 = {rnd128() >> 1} & ~128'h80000000;
    {key_3, key_2, key_1, key_0} = k2;
    {iv_3, iv_2, iv_1, iv_0} = iv2;
    load = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("ready_in_load", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    load = 1'b0;
    chk("reload_out_valid", 128'(out_valid), 128'(0));
    chk("reload_blk_count", 128'(blk_count), 128'(0));
    chk("reload_flushed", 128'(in_ready), 128'(0));
    chk("reload_ctr_wrap", 128'(ctr_wrap), 128'(0));
    d = rnd128();
    xfer(d, r);
    chk("reload_new_iv", r, d ^ iv2 ^ k2);

    // Decrypt round-trip
    k2  = rnd128();
    iv2 = rnd128() & ~128'h80000000;
    do_load(k2, iv2);
    for (int i = 0; i < 5; i++) begin
      pt[i] = rnd128();
      xfer(pt[i], ct[i]);
    end
    do_load(k2, iv2);
    for (int i = 0; i < 5; i++) begin
      xfer(ct[i], r);
      chk($sformatf("roundtrip%0d", i), r, pt[i]);
    end

    // Random traffic with random back-pressure
    do_load(rnd128(), rnd128() & ~128'h80000000);
    repeat (400) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      in_data   = rnd128();
      @(posedge clk); #1;
    end
    chk("random_progress", 128'(blk_count != 0), 128'(1));

    // Reset mid-stream
    in_valid = 1'b1;
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_blk_count", 128'(blk_count), 128'(0));
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_idle", 128'(in_ready), 128'(0));
    chk("mid_rst_core_pt", core_plain_text, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
